eth_mac_tx_arbiter: RTL
=======================

# eth_mac_tx_arbiter

Packet-granular round-robin arbiter that merges `NUM_SRC` FWFT byte streams, such as the CS command-reply path and local reply generators, into the single byte stream consumed by the Ethernet MAC TX. It sits directly downstream of each source's `o_mac_tx_arb_*` outputs and drives each source's `i_mac_tx_arb_byte_rd`. The arbiter grants a source only when that source advertises a complete frame, and never interleaves frames. It enforces a maximum frame length and counts overlong frames and mid-frame underruns.

## Interface
- `NUM_SRC`, default 2: number of sources, 2..8.
- `MAX_FRAME_BYTES`, default `ETH_FRAME_MAX_BYTES`: byte limit per frame before forced termination.
- `GAP_CYCLES`, default 2: idle cycles after each frame before the next arbitration; 0 allowed.

Ports:
- `i_eth_mac_tx_clk`  in  1  sole clock.
- `i_eth_mac_tx_clk_srst`  in  1  reset, synchronous, active-high.
- `i_src_frame_avail`  in  NUM_SRC  complete frame queued at source i.
- `i_src_byte_vld`  in  NUM_SRC  FWFT data valid at source i.
- `i_src_last_byte`  in  NUM_SRC  current byte of source i ends its frame.
- `i_src_byte`  in  NUM_SRC*8  byte of source i, at bits [8i+7:8i].
- `o_src_byte_rd`  out  NUM_SRC  pops source i (FWFT read).
- `i_mac_tx_byte_rd`  in  1  MAC accepts a byte this cycle.
- `o_mac_tx_byte_vld`  out  1  byte valid to MAC.
- `o_mac_tx_last_byte`  out  1  final byte of frame.
- `o_mac_tx_byte`  out  8  byte to MAC.
- `o_grant`  out  NUM_SRC  one-hot current owner; all zero when not in XFER or DRAIN.
- `o_overlong_frames`  out  16  count of truncated frames; wraps.
- `o_underrun_cycles`  out  16  count of mid-frame starvation cycles; wraps.

## Operation
- States:
  - IDLE: round-robin scan of `i_src_frame_avail`, starting at `last_grant+1` mod `NUM_SRC`. On a hit, register the grant, clear `byte_cnt` and go to XFER. No hit: stay in IDLE.
  - XFER: `o_mac_tx_byte_vld = i_src_byte_vld[g]`. Byte and last are passed through from source g combinationally. `o_src_byte_rd[g] = i_mac_tx_byte_rd & i_src_byte_vld[g]`.
    - A transfer occurs when `vld & rd` are both high. Each transfer increments `byte_cnt`, which is `$clog2(MAX_FRAME_BYTES+1)` bits wide.
    - A transfer with `i_src_last_byte[g]` ends the frame. Update `last_grant=g`, then go to GAP (or IDLE if `GAP_CYCLES=0`).
    - A transfer where `byte_cnt==MAX_FRAME_BYTES-1` and the source's last is low: force `o_mac_tx_last_byte=1` on that byte, increment `o_overlong_frames`, go to DRAIN.
    - A cycle with `i_mac_tx_byte_rd=1` and `i_src_byte_vld[g]=0` increments `o_underrun_cycles`. State is held.
- DRAIN: MAC outputs are 0. `o_src_byte_rd[g] = i_src_byte_vld[g]`. Discard bytes until a popped byte has last set, then go to GAP/IDLE with `last_grant=g`.
- GAP: down-counter runs from `GAP_CYCLES-1` to 0; when it reaches 0, go to IDLE.
- `o_src_byte_rd` is zero for every non-granted source, and for all sources in IDLE and GAP.
- `i_src_frame_avail` is sampled only in IDLE. Deassertion during XFER is ignored.

## Timing
- Reset: state IDLE, `last_grant=NUM_SRC-1` (so source 0 has first priority), counters 0. All outputs 0 in the cycle after the reset edge.
- Reset mid-frame aborts immediately: no forced last, and the error counters clear.
- Arbitration latency: avail sampled high in IDLE at cycle n; grant and first possible transfer at cycle n+1.
- Back-to-back frames from the same or another source are separated by exactly `GAP_CYCLES+1` non-XFER cycles.
- Data path from source to MAC is combinational, zero latency. Control (state, grant, counters) is registered.
- A 1-byte frame (last set on the first byte) is legal.
- Error counters wrap from 0xFFFF to 0x0000.

## Structure
- `ethernet_support_pkg` provides `ETH_FRAME_MAX_BYTES`.
- Add the `arb_state_t` enum {IDLE, XFER, DRAIN, GAP} to that package, where it is shared with other MAC TX blocks.
- One sub-module: `rr_priority_select`, a combinational block with inputs `req[NUM_SRC]` and `last_grant`, and outputs one-hot `gnt` and `gnt_vld`.

## Test plan
- Src0 avail with a 60-byte frame, MAC rd always 1 → grant appears 1 cycle after avail; 60 consecutive bytes; last only on byte 60; then 3 idle cycles (`GAP_CYCLES=2`).
- Both sources avail continuously → grants alternate 0,1,0,1. No byte interleaving: `o_grant` is constant between each last and the next grant.
- MAC rd toggling 1010… → each byte is popped exactly once and the sequence matches the source; `o_src_byte_rd` never asserts while MAC rd is low.
- `MAX_FRAME_BYTES=64`, 100-byte frame → byte 64 carries last; 36 bytes drained with MAC vld=0; `o_overlong_frames=1`; the next frame is intact.
- Source vld drops for 5 cycles mid-frame with MAC rd=1 → `o_underrun_cycles=5`; frame completes intact. Then assert reset mid-frame → all outputs 0 the next cycle, src0 has priority afterwards.

Source files
------------

// File: rtl/ethernet_support_pkg.sv
// Shared Ethernet constants and types for the MAC TX path.
package ethernet_support_pkg;

    localparam int ETH_FRAME_MAX_BYTES = 1518;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        GAP
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_priority_select #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] gnt,
    output logic               gnt_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        // k = NUM_SRC revisits last_grant itself, so a lone requester can win again
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant) + k) % NUM_SRC;
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_mac_tx_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC FWFT byte streams into the MAC TX stream.
module eth_mac_tx_arbiter
    import ethernet_support_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int MAX_FRAME_BYTES = ETH_FRAME_MAX_BYTES,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                 i_eth_mac_tx_clk,
    input  logic                 i_eth_mac_tx_clk_srst,
    input  logic [NUM_SRC-1:0]   i_src_frame_avail,
    input  logic [NUM_SRC-1:0]   i_src_byte_vld,
    input  logic [NUM_SRC-1:0]   i_src_last_byte,
    input  logic [NUM_SRC*8-1:0] i_src_byte,
    output logic [NUM_SRC-1:0]   o_src_byte_rd,
    input  logic                 i_mac_tx_byte_rd,
    output logic                 o_mac_tx_byte_vld,
    output logic                 o_mac_tx_last_byte,
    output logic [7:0]           o_mac_tx_byte,
    output logic [NUM_SRC-1:0]   o_grant,
    output logic [15:0]          o_overlong_frames,
    output logic [15:0]          o_underrun_cycles
);

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t         state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic [CNT_W-1:0]   byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [NUM_SRC-1:0] sel_gnt;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;

    logic               g_vld;
    logic               g_last;
    logic [7:0]         g_byte;
    logic               at_limit;
    logic               xfer;

    rr_priority_select #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req        (i_src_frame_avail),
        .last_grant (last_grant),
        .gnt        (sel_gnt),
        .gnt_vld    (sel_vld)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_gnt[i]) sel_idx = IDX_W'(i);
        end
    end

    // Granted source's FWFT head, muxed without a register
    always_comb begin
        g_vld  = 1'b0;
        g_last = 1'b0;
        g_byte = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                g_vld  = i_src_byte_vld[i];
                g_last = i_src_last_byte[i];
                g_byte = i_src_byte[8*i +: 8];
            end
        end
    end

    assign at_limit = (byte_cnt == CNT_W'(MAX_FRAME_BYTES - 1));
    assign xfer     = (state == XFER) && g_vld && i_mac_tx_byte_rd;

    always_comb begin
        o_grant            = '0;
        o_src_byte_rd      = '0;
        o_mac_tx_byte_vld  = 1'b0;
        o_mac_tx_last_byte = 1'b0;
        o_mac_tx_byte      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                if (state == XFER) begin
                    o_grant[i]       = 1'b1;
                    o_src_byte_rd[i] = i_mac_tx_byte_rd & g_vld;
                end else if (state == DRAIN) begin
                    o_grant[i]       = 1'b1;
                    o_src_byte_rd[i] = g_vld;
                end
            end
        end
        if (state == XFER) begin
            o_mac_tx_byte_vld  = g_vld;
            o_mac_tx_byte      = g_byte;
            o_mac_tx_last_byte = g_vld & (g_last | at_limit);
        end
    end

    always_ff @(posedge i_eth_mac_tx_clk) begin
        if (i_eth_mac_tx_clk_srst) begin
            state             <= IDLE;
            last_grant        <= IDX_W'(NUM_SRC - 1);
            gnt_idx           <= '0;
            byte_cnt          <= '0;
            gap_cnt           <= '0;
            o_overlong_frames <= '0;
            o_underrun_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gnt_idx  <= sel_idx;
                        byte_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (i_mac_tx_byte_rd && !g_vld)
                        o_underrun_cycles <= o_underrun_cycles + 16'd1;
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (g_last) begin
                            last_grant <= gnt_idx;
                            if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                            end
                        end else if (at_limit) begin
                            o_overlong_frames <= o_overlong_frames + 16'd1;
                            state             <= DRAIN;
                        end
                    end
                end
                // Truncated frame: keep popping until the source's own last byte
                DRAIN: begin
                    if (g_vld && g_last) begin
                        last_grant <= gnt_idx;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
